// File: rtl/act_mem_readout.sv
// Streaming read-out engine for the activation SRAM: issues row reads from a start
// address and forwards the returned 32-bit words on a valid/ready stream.
module act_mem_readout #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]    n_words_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_req_o,
    output logic [ADDR_W-3:0]   mem_addr_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    input  logic                out_ready_i,
    output logic [1:0]          dbg_state_o,
    output logic [1:0]          dbg_fifo_count_o
);

    // Stream handshake: a word transfers in every cycle where out_valid_o and
    // out_ready_i are both high; while valid is high and ready low, data holds.

    localparam int ROW_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ROW_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    recv_cnt;
    logic                inflight;
    logic [DATA_W-1:0]   fifo_mem [2];
    logic                wr_idx;
    logic                rd_idx;
    logic [1:0]          fifo_count;
    logic                push;
    logic                pop;
    logic [2:0]          occupancy;
    logic                accept;

    // Byte-offset bits of the start address carry no information for row reads.
    logic unused_addr_bits;
    assign unused_addr_bits = ^base_addr_i[1:0];

    assign push        = inflight;
    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (fifo_count != 2'd0);
    assign out_data_o  = fifo_mem[rd_idx];
    assign mem_addr_o  = rd_ptr;
    assign accept      = (state == S_IDLE) && start_i;

    // Words already buffered plus the one in flight, net of the word leaving now.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign dbg_state_o      = state;
    assign dbg_fifo_count_o = fifo_count;

    always_comb begin
        state_nxt = state;
        mem_req_o = 1'b0;
        done_o    = 1'b0;
        busy_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (n_words_i == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                busy_o    = 1'b1;
                mem_req_o = (issue_cnt != '0) && (occupancy < 3'd2);
                if (pop && (recv_cnt == CNT_W'(1))) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= mem_req_o;
            if (accept) begin
                rd_ptr    <= base_addr_i[ADDR_W-1:2];
                issue_cnt <= n_words_i;
                recv_cnt  <= n_words_i;
            end else begin
                // Row pointer wraps naturally at the top of the memory.
                if (mem_req_o) begin
                    rd_ptr    <= rd_ptr + ROW_W'(1);
                    issue_cnt <= issue_cnt - CNT_W'(1);
                end
                if (pop) begin
                    recv_cnt <= recv_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= mem_rdata_i;
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
